// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: phase codes, direction constants
// and the step classifier used by the counter.
package quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    MvNone,
    MvUp,
    MvDown,
    MvIllegal
  } move_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Position of an AB code along the forward cycle 00 -> up_first -> 11 -> ~up_first.
  function automatic logic [1:0] phase_pos(input logic [1:0] ab, input logic [1:0] up_first);
    if (ab == 2'b00) begin
      return 2'd0;
    end else if (ab == 2'b11) begin
      return 2'd2;
    end else if (ab == up_first) begin
      return 2'd1;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic move_e classify(input logic [1:0] prev, input logic [1:0] cur,
                                     input logic [1:0] up_first);
    logic [1:0] delta;
    move_e      mv;
    delta = phase_pos(cur, up_first) - phase_pos(prev, up_first);
    unique case (delta)
      2'd0:    mv = MvNone;
      2'd1:    mv = MvUp;
      2'd2:    mv = MvIllegal;
      default: mv = MvDown;
    endcase
    return mv;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous single-bit input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder with a loadable WIDTH-bit position counter, wrap pulse and
// sticky illegal-transition flag. All outputs are registered.
module quad_decoder_counter
  import quad_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter logic [1:0]  UP_SEQ_AB = 2'b10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  logic       a_sync, b_sync;
  logic [1:0] ab_sync;
  phase_e     phase_q;
  logic       armed_q;
  logic [1:0] fill_q;
  move_e      mv;

  sync_2ff u_sync_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (quad_a),
    .q     (a_sync)
  );

  sync_2ff u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (quad_b),
    .q     (b_sync)
  );

  assign ab_sync = {a_sync, b_sync};

  always_comb begin
    mv = MvNone;
    if (armed_q) begin
      mv = classify(phase_q, ab_sync, UP_SEQ_AB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      dir     <= DIR_UP;
      step    <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
      phase_q <= S00;
      armed_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      step   <= 1'b0;
      wrap   <= 1'b0;
      // fill_q[1] marks that the synchronizer output holds a post-reset sample.
      fill_q <= {fill_q[0], 1'b1};

      if (armed_q) begin
        phase_q <= phase_e'(ab_sync);
      end else if (fill_q[1]) begin
        phase_q <= phase_e'(ab_sync);
        armed_q <= 1'b1;
      end

      if (mv == MvIllegal) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end

      if (load) begin
        count <= d_in;
      end else if (mv == MvUp) begin
        count <= count + 1'b1;
        step  <= 1'b1;
        dir   <= DIR_UP;
        wrap  <= &count;
      end else if (mv == MvDown) begin
        count <= count - 1'b1;
        step  <= 1'b1;
        dir   <= DIR_DN;
        wrap  <= (count == '0);
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Self-checking bench for quad_decoder_counter against a position-arithmetic model.
module tb_quad_decoder_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d_in = 4'd0;
  logic       clr_err = 1'b0;
  logic [3:0] count;
  logic       dir, step, wrap, err;

  int n_cmp = 0;
  int n_bad = 0;

  quad_decoder_counter #(
    .WIDTH     (4),
    .UP_SEQ_AB (2'b10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .quad_a  (quad_a),
    .quad_b  (quad_b),
    .load    (load),
    .d_in    (d_in),
    .clr_err (clr_err),
    .count   (count),
    .dir     (dir),
    .step    (step),
    .wrap    (wrap),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Reference model: AB samples taken at each edge, decoded two edges later.
  int         m_count;
  bit         m_dir, m_step, m_wrap, m_err, m_armed;
  logic [1:0] m_phase;
  logic [1:0] hist[$];
  int         m_edges;
  logic [1:0] fwd[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] cur_ab;

  function automatic int pos_of(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (fwd[i] == ab) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_count = 0; m_dir = 1; m_step = 0; m_wrap = 0; m_err = 0; m_armed = 0;
    m_phase = 2'b00; m_edges = 0;
    hist.delete();
  endtask

  task automatic cycle(input logic [1:0] ab, input bit ld = 0, input logic [3:0] d = 0,
                       input bit clr = 0);
    int mv;
    logic [1:0] seen;
    quad_a = ab[1]; quad_b = ab[0]; load = ld; d_in = d; clr_err = clr; cur_ab = ab;
    @(posedge clk);
    hist.push_back(ab);
    m_edges++;
    m_step = 0; m_wrap = 0; mv = 0;
    if (m_edges >= 3) begin
      seen = hist[hist.size() - 3];
      if (!m_armed) begin
        m_armed = 1; m_phase = seen;
      end else begin
        mv = (pos_of(seen) - pos_of(m_phase) + 4) % 4;
        m_phase = seen;
      end
    end
    if (hist.size() > 3) void'(hist.pop_front());
    if (mv == 2) m_err = 1;
    else if (clr) m_err = 0;
    if (ld) m_count = d;
    else if (mv == 1) begin
      m_wrap = (m_count == 15); m_count = (m_count + 1) % 16; m_step = 1; m_dir = 1;
    end else if (mv == 3) begin
      m_wrap = (m_count == 0); m_count = (m_count + 15) % 16; m_step = 1; m_dir = 0;
    end
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] ab);
    quad_a = ab[1]; quad_b = ab[0]; load = 0; clr_err = 0; cur_ab = ab;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int steps_seen = 0;
    apply_reset(2'b11);
    n_cmp++;
    if ({count, dir, step, wrap, err} !== 8'b0000_1_0_0_0) begin
      $display("FAIL reset_values: got %b required %b", {count, dir, step, wrap, err}, 8'b00001000);
      n_bad++;
    end
    for (int i = 0; i < 5; i++) begin
      cycle(2'b11);
      if (step) steps_seen++;
    end
    n_cmp++;
    if (steps_seen != 0 || count !== 4'd0 || err !== 1'b0) begin
      $display("FAIL reset_release: steps=%0d count=%0d err=%b required 0/0/0",
               steps_seen, count, err);
      n_bad++;
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq[5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    int steps_seen = 0;
    int call = 0;
    int change_call[$];
    int step_call[$];
    apply_reset(2'b00);
    repeat (4) cycle(2'b00);
    for (int p = 1; p < 5; p++) begin
      change_call.push_back(call);
      for (int c = 0; c < 4; c++) begin
        cycle(seq[p]);
        if (step) begin
          steps_seen++;
          step_call.push_back(call);
        end
        n_cmp++;
        if (count !== 4'(m_count)) begin
          $display("FAIL fwd_count: got %0d required %0d", count, m_count);
          n_bad++;
        end
        call++;
      end
    end
    n_cmp++;
    if (count !== 4'd4 || steps_seen != 4 || dir !== 1'b1) begin
      $display("FAIL fwd_final: count=%0d steps=%0d dir=%b required 4/4/1", count, steps_seen, dir);
      n_bad++;
    end
    for (int i = 0; i < step_call.size() && i < change_call.size(); i++) begin
      n_cmp++;
      if (step_call[i] - change_call[i] != 2) begin
        $display("FAIL fwd_latency: step %0d after %0d edges required 3", i,
                 step_call[i] - change_call[i] + 1);
        n_bad++;
      end
    end
  endtask

  task automatic test_reverse_wrap();
    int wraps = 0;
    logic [3:0] seen_counts[$];
    cycle(2'b00, 1, 4'b0001);
    n_cmp++;
    if (count !== 4'b0001) begin
      $display("FAIL rev_load: got %b required 0001", count);
      n_bad++;
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(p == 0 ? 2'b01 : 2'b11);
        if (wrap) wraps++;
        if (step) seen_counts.push_back(count);
        n_cmp++;
        if (wrap !== m_wrap) begin
          $display("FAIL rev_wrap_cycle: got %b required %b", wrap, m_wrap);
          n_bad++;
        end
      end
    end
    n_cmp++;
    if (seen_counts.size() != 2 || wraps != 1 || dir !== 1'b0 || count !== 4'b1111) begin
      $display("FAIL rev_final: steps=%0d wraps=%0d dir=%b count=%b required 2/1/0/1111",
               seen_counts.size(), wraps, dir, count);
      n_bad++;
    end else begin
      n_cmp++;
      if (seen_counts[0] !== 4'b0000 || seen_counts[1] !== 4'b1111) begin
        $display("FAIL rev_sequence: got %b,%b required 0000,1111", seen_counts[0],
                 seen_counts[1]);
        n_bad++;
      end
    end
  endtask

  task automatic test_load_collision();
    cycle(2'b01);
    cycle(2'b01);
    cycle(2'b01, 1, 4'b1010);
    n_cmp++;
    if (count !== 4'b1010 || step !== 1'b0 || wrap !== 1'b0) begin
      $display("FAIL load_priority: count=%b step=%b wrap=%b required 1010/0/0", count, step, wrap);
      n_bad++;
    end
    repeat (3) cycle(2'b00);
    n_cmp++;
    if (count !== 4'b1011) begin
      $display("FAIL load_then_step: got %b required 1011", count);
      n_bad++;
    end
  endtask

  task automatic test_error();
    logic [3:0] held;
    logic       held_dir;
    held = count;
    held_dir = dir;
    repeat (3) cycle(2'b11);
    n_cmp++;
    if (err !== 1'b1 || count !== held || dir !== held_dir) begin
      $display("FAIL err_set: err=%b count=%b dir=%b required 1/%b/%b", err, count, dir, held,
               held_dir);
      n_bad++;
    end
    cycle(2'b11, 0, 0, 1);
    n_cmp++;
    if (err !== 1'b0) begin
      $display("FAIL err_clear: got %b required 0", err);
      n_bad++;
    end
    cycle(2'b00);
    cycle(2'b00);
    cycle(2'b00, 0, 0, 1);
    n_cmp++;
    if (err !== 1'b1 || count !== held) begin
      $display("FAIL err_set_priority: err=%b count=%b required 1/%b", err, count, held);
      n_bad++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset(2'b00);
    repeat (3) cycle(2'b00);
    cycle(2'b00, 1, 4'd7);
    cycle(2'b10);
    n_cmp++;
    if (count !== 4'd7) begin
      $display("FAIL async_pre: got %0d required 7", count);
      n_bad++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (count !== 4'd0 || step !== 1'b0) begin
      $display("FAIL async_reset: count=%0d step=%b required 0/0", count, step);
      n_bad++;
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] ab = 2'b00;
    apply_reset(2'b00);
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      bit ld = ($urandom_range(0, 19) == 0);
      bit clr = ($urandom_range(0, 9) == 0);
      logic [3:0] d = 4'($urandom);
      if (r < 30) ab = fwd[(pos_of(ab) + 1) % 4];
      else if (r < 60) ab = fwd[(pos_of(ab) + 3) % 4];
      else if (r < 64) ab = ~ab;
      cycle(ab, ld, d, clr);
      n_cmp++;
      if ({count, dir, step, wrap, err} !== {4'(m_count), m_dir, m_step, m_wrap, m_err}) begin
        $display("FAIL random[%0d]: got c/d/s/w/e=%b required %b", i,
                 {count, dir, step, wrap, err}, {4'(m_count), m_dir, m_step, m_wrap, m_err});
        n_bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_load_collision();
    test_error();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
